wb_master_arbiter: RTL

Two-master Wishbone arbiter that shares the mainboard's 8-bit, 24-bit-address Wishbone slave port between the host debug/overlay master (m0) and the ROM/GROM loader master (m1). It grants the bus per Wishbone cycle with round-robin fairness and passes data and ack through combinationally. A bus-timeout watchdog terminates strobes that receive no ack.

---
 rtl/wb_arb_pkg.sv | 19 +
 rtl/wb_master_arbiter_if.sv | 19 +
 rtl/wb_timeout_watchdog.sv | 45 ++++
 rtl/wb_master_arbiter.sv | 109 ++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and sizing helpers for the two-master Wishbone arbiter.
package wb_arb_pkg;

  localparam int unsigned WB_ADR_W = 24;
  localparam int unsigned WB_DAT_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } arb_state_e;

  // Width needed to count 0..limit; never narrower than one bit so a
  // disabled watchdog (limit 0) still elaborates.
  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit == 0) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/wb_master_arbiter_if.sv
// One Wishbone link; the arbiter is the slave of each master link and the master of the board link.
interface wb_master_arbiter_if;
  import wb_arb_pkg::*;

  logic [WB_ADR_W-1:0] adr;
  logic [WB_DAT_W-1:0] dat_w;
  logic [WB_DAT_W-1:0] dat_r;
  logic                we;
  logic [0:0]          sel;
  logic                stb;
  logic                cyc;
  logic                ack;
  logic                err;

  // The board slave has no error line, so the master view omits err.
  modport master (output adr, dat_w, we, sel, stb, cyc, input dat_r, ack);
  modport slave  (input adr, dat_w, we, sel, stb, cyc, output dat_r, ack, err);

endinterface

// File: rtl/wb_timeout_watchdog.sv
// Counts unacked strobe cycles, aborts the strobe at the limit and keeps a sticky timeout flag.
module wb_timeout_watchdog
  import wb_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic i_stb_raw,
  input  logic i_ack,
  input  logic i_restart,
  output logic o_abort,
  output logic o_timeout_seen
);

  localparam int unsigned     CW    = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CW-1:0]   LIMIT = CW'(TIMEOUT_CYCLES);
  localparam logic            EN    = (TIMEOUT_CYCLES != 0);

  logic [CW-1:0] r_count;
  logic          r_seen;
  logic          w_hit;

  assign w_hit          = EN & (r_count == LIMIT);
  // A coincident ack always wins over the abort.
  assign o_abort        = w_hit & i_stb_raw & ~i_ack;
  assign o_timeout_seen = r_seen;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
      r_seen  <= 1'b0;
    end else begin
      if (!EN || i_restart || !i_stb_raw || i_ack || o_abort) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + 1'b1;
      end
      if (o_abort) begin
        r_seen <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_master_arbiter.sv
// Round-robin two-master Wishbone arbiter with per-cycle grant and combinational response routing.
module wb_master_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                       clk,
  input  logic                       reset,
  wb_master_arbiter_if.slave         m0,
  wb_master_arbiter_if.slave         m1,
  wb_master_arbiter_if.master        s,
  output logic [1:0]                 grant,
  output logic                       timeout_seen
);

  arb_state_e r_state;
  arb_state_e w_state_nxt;
  logic       r_last_owner;
  logic       w_stb_raw;
  logic       w_abort;
  logic       w_restart;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_last_owner <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      if (w_state_nxt == GRANT0) begin
        r_last_owner <= 1'b0;
      end else if (w_state_nxt == GRANT1) begin
        r_last_owner <= 1'b1;
      end
    end
  end

  // Owners always pass through IDLE, which gives the one-cycle bubble between grants.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (m0.cyc && m1.cyc) begin
          w_state_nxt = r_last_owner ? GRANT0 : GRANT1;
        end else if (m0.cyc) begin
          w_state_nxt = GRANT0;
        end else if (m1.cyc) begin
          w_state_nxt = GRANT1;
        end
      end
      GRANT0:  if (!m0.cyc) w_state_nxt = IDLE;
      GRANT1:  if (!m1.cyc) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    grant     = 2'b00;
    s.cyc     = 1'b0;
    w_stb_raw = 1'b0;
    s.adr     = '0;
    s.dat_w   = '0;
    s.we      = 1'b0;
    s.sel     = '0;
    case (r_state)
      GRANT0: begin
        grant     = 2'b01;
        s.cyc     = m0.cyc;
        w_stb_raw = m0.stb & m0.cyc;
        s.adr     = m0.adr;
        s.dat_w   = m0.dat_w;
        s.we      = m0.we;
        s.sel     = m0.sel;
      end
      GRANT1: begin
        grant     = 2'b10;
        s.cyc     = m1.cyc;
        w_stb_raw = m1.stb & m1.cyc;
        s.adr     = m1.adr;
        s.dat_w   = m1.dat_w;
        s.we      = m1.we;
        s.sel     = m1.sel;
      end
      default: ;
    endcase
  end

  assign s.stb     = w_stb_raw & ~w_abort;
  assign w_restart = (w_state_nxt != r_state);

  assign m0.ack   = s.ack & grant[0];
  assign m1.ack   = s.ack & grant[1];
  assign m0.err   = w_abort & grant[0];
  assign m1.err   = w_abort & grant[1];
  assign m0.dat_r = grant[0] ? s.dat_r : '0;
  assign m1.dat_r = grant[1] ? s.dat_r : '0;

  wb_timeout_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk            (clk),
    .reset          (reset),
    .i_stb_raw      (w_stb_raw),
    .i_ack          (s.ack),
    .i_restart      (w_restart),
    .o_abort        (w_abort),
    .o_timeout_seen (timeout_seen)
  );

endmodule
